// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register of the 5-stage RV32I core. It sits directly behind
// the register file and takes that file's asynchronous read data (RD1/RD2).
//
// What it does:
//   - Write-back bypass: if the register file is written on the same edge that
//     the operands are captured, the value being written is captured instead of
//     the stale read data. Register x0 always reads as zero and a write to x0
//     is never bypassed.
//   - Load-use hazard: if the instruction in EX is a load and its destination
//     is read by the instruction in decode, a bubble goes into EX and stall_d
//     freezes PC and IF/ID for one cycle.
//   - A branch flush kills the instruction that would enter EX.
//   - hold_e freezes the whole register, including the bubble counter.
//   - bubble_cnt counts inserted load-use bubbles and saturates at all-ones.
//
// Ports:
//   CLK, Reset            clock, synchronous active-high reset
//   flush                 kill the instruction entering EX
//   hold_e                EX busy, freeze ID/EX
//   valid_d, pc_d, rs1_d, rs2_d, rd_d, use_rs1_d, use_rs2_d, imm_d, ctrl_d
//                         decoded instruction fields
//   RD1, RD2              register file read data for rs1_d / rs2_d
//   wb_we, wb_rd, wb_data write-back port (same signals as the register file)
//   stall_d               combinational stall to PC and IF/ID
//   valid_e, pc_e, imm_e, rs1_e, rs2_e, rd_e, src_a_e, src_b_e, ctrl_e
//                         registered EX-stage copies
//   bubble_cnt            saturating count of load-use bubbles
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              Reset,

    input  logic              flush,
    input  logic              hold_e,

    input  logic              valid_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic [4:0]        rs1_d,
    input  logic [4:0]        rs2_d,
    input  logic [4:0]        rd_d,
    input  logic              use_rs1_d,
    input  logic              use_rs2_d,
    input  logic [XLEN-1:0]   imm_d,
    input  logic [CTRL_W-1:0] ctrl_d,

    input  logic [XLEN-1:0]   RD1,
    input  logic [XLEN-1:0]   RD2,

    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,

    output logic              stall_d,
    output logic              valid_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [XLEN-1:0]   imm_e,
    output logic [4:0]        rs1_e,
    output logic [4:0]        rs2_e,
    output logic [4:0]        rd_e,
    output logic [XLEN-1:0]   src_a_e,
    output logic [XLEN-1:0]   src_b_e,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int CTRL_MEM_READ = 1;

    logic [XLEN-1:0] src_a_d;
    logic [XLEN-1:0] src_b_d;
    logic            rs1_hit;
    logic            rs2_hit;
    logic            haz;
    logic            cnt_sat;

    // Bypass only fires for a real write to a non-zero register; x0 is forced
    // to zero regardless of what the register file returns.
    always_comb begin
        src_a_d = RD1;
        src_b_d = RD2;

        if (rs1_d == 5'd0)
            src_a_d = '0;
        else if (wb_we && (wb_rd == rs1_d) && (wb_rd != 5'd0))
            src_a_d = wb_data;

        if (rs2_d == 5'd0)
            src_b_d = '0;
        else if (wb_we && (wb_rd == rs2_d) && (wb_rd != 5'd0))
            src_b_d = wb_data;
    end

    // A load in EX whose result is needed by the decode instruction.
    always_comb begin
        rs1_hit = use_rs1_d && (rs1_d == rd_e);
        rs2_hit = use_rs2_d && (rs2_d == rd_e);
        haz     = valid_d && valid_e && ctrl_e[CTRL_MEM_READ] &&
                  (rd_e != 5'd0) && (rs1_hit || rs2_hit);
    end

    // flush overrides both hold and hazard: the redirected fetch must not stall.
    assign stall_d = !flush && (hold_e || haz);

    assign cnt_sat = &bubble_cnt;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            valid_e    <= 1'b0;
            pc_e       <= '0;
            imm_e      <= '0;
            rs1_e      <= 5'd0;
            rs2_e      <= 5'd0;
            rd_e       <= 5'd0;
            src_a_e    <= '0;
            src_b_e    <= '0;
            ctrl_e     <= '0;
            bubble_cnt <= '0;
        end else if (flush) begin
            valid_e    <= 1'b0;
            pc_e       <= '0;
            imm_e      <= '0;
            rs1_e      <= 5'd0;
            rs2_e      <= 5'd0;
            rd_e       <= 5'd0;
            src_a_e    <= '0;
            src_b_e    <= '0;
            ctrl_e     <= '0;
        end else if (hold_e) begin
            valid_e    <= valid_e;
        end else if (haz) begin
            // Bubble: clearing ctrl_e guarantees no reg_write or mem_read, and
            // clearing valid_e means the same hazard cannot repeat next cycle.
            valid_e    <= 1'b0;
            ctrl_e     <= '0;
            rd_e       <= 5'd0;
            if (!cnt_sat)
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end else begin
            valid_e    <= valid_d;
            pc_e       <= pc_d;
            imm_e      <= imm_d;
            rs1_e      <= rs1_d;
            rs2_e      <= rs2_d;
            rd_e       <= rd_d;
            src_a_e    <= src_a_d;
            src_b_e    <= src_b_d;
            ctrl_e     <= valid_d ? ctrl_d : '0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 16;
    localparam int CNT_S  = 3;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic              Reset;
    logic              flush, hold_e, valid_d, use_rs1_d, use_rs2_d, wb_we;
    logic [XLEN-1:0]   pc_d, imm_d, RD1, RD2, wb_data;
    logic [4:0]        rs1_d, rs2_d, rd_d, wb_rd;
    logic [CTRL_W-1:0] ctrl_d;

    logic              stall_d, valid_e;
    logic [XLEN-1:0]   pc_e, imm_e, src_a_e, src_b_e;
    logic [4:0]        rs1_e, rs2_e, rd_e;
    logic [CTRL_W-1:0] ctrl_e;
    logic [CNT_W-1:0]  bubble_cnt;

    logic              s_stall_d, s_valid_e;
    logic [XLEN-1:0]   s_pc_e, s_imm_e, s_src_a_e, s_src_b_e;
    logic [4:0]        s_rs1_e, s_rs2_e, s_rd_e;
    logic [CTRL_W-1:0] s_ctrl_e;
    logic [CNT_S-1:0]  s_bubble_cnt;

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .Reset(Reset), .flush(flush), .hold_e(hold_e),
        .valid_d(valid_d), .pc_d(pc_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .imm_d(imm_d), .ctrl_d(ctrl_d),
        .RD1(RD1), .RD2(RD2), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_d(stall_d), .valid_e(valid_e), .pc_e(pc_e), .imm_e(imm_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .src_a_e(src_a_e), .src_b_e(src_b_e),
        .ctrl_e(ctrl_e), .bubble_cnt(bubble_cnt)
    );

    // Narrow-counter copy so saturation is reachable in a short run.
    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_S)) u_sat (
        .CLK(CLK), .Reset(Reset), .flush(flush), .hold_e(hold_e),
        .valid_d(valid_d), .pc_d(pc_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .imm_d(imm_d), .ctrl_d(ctrl_d),
        .RD1(RD1), .RD2(RD2), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_d(s_stall_d), .valid_e(s_valid_e), .pc_e(s_pc_e), .imm_e(s_imm_e),
        .rs1_e(s_rs1_e), .rs2_e(s_rs2_e), .rd_e(s_rd_e), .src_a_e(s_src_a_e),
        .src_b_e(s_src_b_e), .ctrl_e(s_ctrl_e), .bubble_cnt(s_bubble_cnt)
    );

    int vectors = 0;
    int miscompares = 0;

    // Architectural register file the DUT's RD1/RD2 are served from.
    logic [XLEN-1:0] rf [32];

    // Reference view of the instruction sitting in EX.
    logic              m_valid;
    logic [XLEN-1:0]   m_pc, m_imm, m_a, m_b;
    logic [4:0]        m_rs1, m_rs2, m_rd;
    logic [CTRL_W-1:0] m_ctrl;
    longint            m_bubbles;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_haz();
        return valid_d && m_valid && m_ctrl[1] && (m_rd != 5'd0) &&
               ((use_rs1_d && rs1_d == m_rd) || (use_rs2_d && rs2_d == m_rd));
    endfunction

    // Value register rs holds once this edge's write-back has committed.
    function automatic logic [XLEN-1:0] arch_val(input logic [4:0] rs);
        if (rs == 5'd0) return '0;
        if (wb_we && wb_rd == rs) return wb_data;
        return rf[rs];
    endfunction

    function automatic logic [63:0] sat(input longint n, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (n > mx) ? 64'(mx) : 64'(n);
    endfunction

    task automatic check_ex(input string tag, input logic v, input logic [XLEN-1:0] pc,
                            input logic [XLEN-1:0] imm, input logic [4:0] r1, input logic [4:0] r2,
                            input logic [4:0] rd, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input logic [CTRL_W-1:0] c, input logic [63:0] cnt, input int w);
        chk({tag, "valid_e"}, 64'(v), 64'(m_valid));
        chk({tag, "ctrl_e"}, 64'(c), 64'(m_ctrl));
        chk({tag, "rd_e"}, 64'(rd), 64'(m_rd));
        chk({tag, "bubble_cnt"}, cnt, sat(m_bubbles, w));
        if (m_valid) begin
            chk({tag, "pc_e"}, 64'(pc), 64'(m_pc));
            chk({tag, "imm_e"}, 64'(imm), 64'(m_imm));
            chk({tag, "rs1_e"}, 64'(r1), 64'(m_rs1));
            chk({tag, "rs2_e"}, 64'(r2), 64'(m_rs2));
            chk({tag, "src_a_e"}, 64'(a), 64'(m_a));
            chk({tag, "src_b_e"}, 64'(b), 64'(m_b));
        end
    endtask

    // One clock: present RD data, check the stall, advance the model, check EX.
    task automatic step();
        bit exp_stall;
        RD1 = (rs1_d == 5'd0) ? $urandom : rf[rs1_d];
        RD2 = (rs2_d == 5'd0) ? $urandom : rf[rs2_d];
        #1;
        exp_stall = !flush && (hold_e || model_haz());
        chk("stall_d", 64'(stall_d), 64'(exp_stall));
        chk("sat.stall_d", 64'(s_stall_d), 64'(exp_stall));

        if (Reset) begin
            m_valid = 0; m_pc = '0; m_imm = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
            m_a = '0; m_b = '0; m_ctrl = '0; m_bubbles = 0;
        end else if (flush) begin
            m_valid = 0; m_ctrl = '0; m_rd = '0;
        end else if (hold_e) begin
            m_valid = m_valid;
        end else if (model_haz()) begin
            m_valid = 0; m_ctrl = '0; m_rd = '0; m_bubbles++;
        end else begin
            m_valid = valid_d; m_pc = pc_d; m_imm = imm_d;
            m_rs1 = rs1_d; m_rs2 = rs2_d; m_rd = rd_d;
            m_a = arch_val(rs1_d); m_b = arch_val(rs2_d);
            m_ctrl = valid_d ? ctrl_d : '0;
        end
        if (wb_we && wb_rd != 5'd0) rf[wb_rd] = wb_data;

        @(posedge CLK);
        #1;
        check_ex("", valid_e, pc_e, imm_e, rs1_e, rs2_e, rd_e, src_a_e, src_b_e, ctrl_e,
                 64'(bubble_cnt), CNT_W);
        check_ex("sat.", s_valid_e, s_pc_e, s_imm_e, s_rs1_e, s_rs2_e, s_rd_e, s_src_a_e,
                 s_src_b_e, s_ctrl_e, 64'(s_bubble_cnt), CNT_S);
    endtask

    task automatic set_instr(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                             input logic u1, input logic u2, input logic [CTRL_W-1:0] c);
        valid_d = 1'b1; rd_d = rd; rs1_d = r1; rs2_d = r2;
        use_rs1_d = u1; use_rs2_d = u2; ctrl_d = c;
        pc_d = $urandom; imm_d = $urandom;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? '0 : $urandom;
        Reset = 1; flush = 0; hold_e = 0; wb_we = 0; wb_rd = '0; wb_data = '0;
        set_instr(5'd1, 5'd2, 5'd3, 1, 1, 8'h03);
        RD1 = '0; RD2 = '0;
        m_valid = 0; m_pc = '0; m_imm = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
        m_a = '0; m_b = '0; m_ctrl = '0; m_bubbles = 0;
        @(posedge CLK);
        #1;

        // Reset with a valid load presented for two cycles.
        step(); step();
        chk("lit_reset_valid_e", 64'(valid_e), 64'd0);
        chk("lit_reset_ctrl_e", 64'(ctrl_e), 64'd0);
        chk("lit_reset_cnt", 64'(bubble_cnt), 64'd0);
        chk("lit_reset_stall", 64'(stall_d), 64'd0);
        Reset = 0;

        // Same-cycle write-back bypass, then x0 never bypassed.
        set_instr(5'd9, 5'd5, 5'd6, 1, 0, 8'h01);
        rf[5] = 32'h11111111;
        wb_we = 1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        step();
        chk("lit_bypass_src_a", 64'(src_a_e), 64'hDEADBEEF);
        set_instr(5'd9, 5'd0, 5'd6, 1, 0, 8'h01);
        wb_rd = 5'd0; wb_data = 32'h12345678;
        step();
        chk("lit_x0_src_a", 64'(src_a_e), 64'd0);
        wb_we = 0;

        // Load-use: lw x7 then add x8,x7,x1.
        set_instr(5'd7, 5'd2, 5'd0, 1, 0, 8'h03);
        step();
        set_instr(5'd8, 5'd7, 5'd1, 1, 1, 8'h01);
        #1 chk("lit_lu_stall", 64'(stall_d), 64'd1);
        step();
        chk("lit_lu_bubble_valid", 64'(valid_e), 64'd0);
        chk("lit_lu_bubble_ctrl", 64'(ctrl_e), 64'd0);
        chk("lit_lu_cnt", 64'(bubble_cnt), 64'd1);
        chk("lit_lu_stall_after", 64'(stall_d), 64'd0);
        step();
        chk("lit_lu_add_valid", 64'(valid_e), 64'd1);
        chk("lit_lu_add_rd", 64'(rd_e), 64'd8);

        // No false hazard for an instruction that reads nothing.
        set_instr(5'd7, 5'd2, 5'd0, 1, 0, 8'h03);
        step();
        set_instr(5'd8, 5'd7, 5'd7, 0, 0, 8'h01);
        #1 chk("lit_lui_stall", 64'(stall_d), 64'd0);
        step();
        chk("lit_lui_valid", 64'(valid_e), 64'd1);
        chk("lit_lui_cnt", 64'(bubble_cnt), 64'd1);

        // Flush beats a simultaneous hazard.
        set_instr(5'd7, 5'd2, 5'd0, 1, 0, 8'h03);
        step();
        set_instr(5'd8, 5'd7, 5'd1, 1, 1, 8'h01);
        flush = 1;
        #1 chk("lit_flush_stall", 64'(stall_d), 64'd0);
        step();
        flush = 0;
        chk("lit_flush_valid", 64'(valid_e), 64'd0);
        chk("lit_flush_cnt", 64'(bubble_cnt), 64'd1);

        // Hold for three cycles with changing decode inputs.
        set_instr(5'd3, 5'd4, 5'd5, 1, 1, 8'h01);
        pc_d = 32'h100;
        step();
        hold_e = 1;
        for (int i = 0; i < 3; i++) begin
            set_instr(5'($urandom_range(1, 31)), 5'd3, 5'd4, 1, 1, 8'h03);
            #1 chk("lit_hold_stall", 64'(stall_d), 64'd1);
            step();
            chk("lit_hold_pc_e", 64'(pc_e), 64'h100);
        end
        hold_e = 0;

        // Reset arriving while a load-use stall is pending.
        set_instr(5'd7, 5'd2, 5'd0, 1, 0, 8'h03);
        step();
        set_instr(5'd8, 5'd7, 5'd1, 1, 1, 8'h01);
        Reset = 1;
        #1 chk("lit_rst_mid_stall", 64'(stall_d), 64'd1);
        step();
        Reset = 0;
        chk("lit_rst_mid_valid", 64'(valid_e), 64'd0);
        chk("lit_rst_mid_stall_after", 64'(stall_d), 64'd0);

        // Randomized traffic with a small register set to make hazards common.
        for (int n = 0; n < 4000; n++) begin
            set_instr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 1)), 8'($urandom));
            valid_d = ($urandom_range(0, 9) != 0);
            flush   = ($urandom_range(0, 11) == 0);
            hold_e  = ($urandom_range(0, 7) == 0);
            Reset   = ($urandom_range(0, 499) == 0);
            wb_we   = ($urandom_range(0, 2) != 0);
            wb_rd   = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline stage of the 5-stage RV32I core. Sits directly downstream of the register file and consumes its asynchronous RD1/RD2 read data.
- Applies a write-back bypass to cover the same-cycle write/read case, with x0 hard-wired to zero.
- Detects load-use hazards, inserts a bubble and raises stall to IF/ID and PC.
- Handles branch flush and external EX hold.
- Counts inserted load-use bubbles in a saturating counter.

Parameters:
XLEN, 32, datapath width
CTRL_W, 8, width of decoded control bundle; bit0 = reg_write, bit1 = mem_read, others pass-through
CNT_W, 16, width of bubble counter

Ports:
CLK  in  1  clock
Reset  in  1  synchronous reset, active-high
flush  in  1  branch/jump redirect from EX; kill the instruction entering EX
hold_e  in  1  EX stage busy; freeze the ID/EX register
valid_d  in  1  decode-stage instruction valid
pc_d  in  XLEN  decode PC
rs1_d, rs2_d, rd_d  in  5  register indices from the instruction
use_rs1_d, use_rs2_d  in  1  instruction actually reads rs1/rs2
imm_d  in  XLEN  sign-extended immediate
ctrl_d  in  CTRL_W  decoded control bundle
RD1, RD2  in  XLEN  register file read data for rs1_d/rs2_d
wb_we  in  1  write-back write enable (same signal as the register file WE)
wb_rd  in  5  write-back destination (same as register file A3)
wb_data  in  XLEN  write-back data (same as register file WD)
stall_d  out  1  hold PC and IF/ID this cycle (combinational)
valid_e  out  1  EX instruction valid
pc_e, imm_e  out  XLEN  registered copies
rs1_e, rs2_e, rd_e  out  5  registered indices (for forwarding unit)
src_a_e, src_b_e  out  XLEN  registered operand values
ctrl_e  out  CTRL_W  registered control
bubble_cnt  out  CNT_W  number of load-use bubbles inserted

Behaviour:
- Operand select (combinational), rs1 path; rs2 path identical:
  - rs1_d==0 -> 0
  - else if wb_we && wb_rd==rs1_d && wb_rd!=0 -> wb_data
  - else -> RD1
- Load-use hazard (combinational): haz = valid_d && valid_e && ctrl_e[1] && rd_e!=0 && ((use_rs1_d && rs1_d==rd_e) || (use_rs2_d && rs2_d==rd_e)).
- stall_d = !flush && (hold_e || haz).
- Register update at posedge CLK, first match wins:
  1. Reset: all outputs 0, valid_e=0, ctrl_e=0, bubble_cnt=0.
  2. flush: valid_e<=0, ctrl_e<=0. Other fields don't-care; implement them as 0. bubble_cnt is unchanged.
  3. hold_e: all registers hold their value, including bubble_cnt.
  4. haz: bubble. valid_e<=0, ctrl_e<=0, rd_e<=0. bubble_cnt increments, saturating at all-ones.
  5. Otherwise: load all *_d fields. valid_e<=valid_d. ctrl_e<=valid_d ? ctrl_d : 0. src_a/b from operand select.
- Latency: exactly 1 cycle, decode to EX outputs.
- A bubble never has reg_write or mem_read set.
- The register file writes on the same edge it is read. The bypass guarantees the EX operand equals the value being written that cycle.
- Writes to x0 are never bypassed.
- flush and haz in the same cycle: flush wins, stall_d=0, counter unchanged.
- Reset asserted mid-stall: on the next edge all state clears. Next cycle stall_d=0 because valid_e=0.
- Since the bubble clears valid_e, one load-use hazard produces exactly one stall cycle.

Test Plan:
- Reset: drive valid_d=1, ctrl_d=0x03, Reset=1 for 2 cycles -> valid_e=0, ctrl_e=0, bubble_cnt=0, stall_d=0.
- WB bypass: RD1=0x11111111, rs1_d=5, wb_we=1, wb_rd=5, wb_data=0xDEADBEEF -> next cycle src_a_e=0xDEADBEEF. Repeat with wb_rd=0, rs1_d=0 -> src_a_e=0.
- Load-use: EX holds lw x7 (ctrl_e=0x03, rd_e=7); decode add x8,x7,x1 (use_rs1_d=1) -> stall_d=1 for one cycle, then valid_e=0, ctrl_e=0, bubble_cnt=1. Following cycle: add loads, stall_d=0.
- No false hazard: same setup but use_rs1_d=0 and use_rs2_d=0 (e.g. lui) -> stall_d=0, no bubble, counter unchanged.
- Flush priority: hazard condition true and flush=1 -> stall_d=0; next cycle valid_e=0, bubble_cnt unchanged.
- Hold and saturation:
  - hold_e=1 for 3 cycles with changing *_d -> all EX outputs frozen, stall_d=1.
  - Preset path: force 0xFFFF bubbles -> bubble_cnt stays at 0xFFFF.
